// File: rtl/int2float_sched.sv
// Round-robin scheduler that shares one combinational int2float converter
// among NREQ requesters; one operation in flight, result held until accepted.
module int2float_sched #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*11-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [10:0]        conv_x,
    input  logic [6:0]         conv_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [6:0]         rsp_data,
    output logic [IDW-1:0]     rsp_id,
    output logic [15:0]        conv_count
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        RESP
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] ptr_q;
    logic [10:0]    opnd_q;
    logic [IDW-1:0] id_q;
    logic [6:0]     rsp_data_q;
    logic [15:0]    cnt_q;

    logic           found;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] ptr_d;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        gnt   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                gnt   = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        if (gnt == IDW'(NREQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt + 1'b1;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && found) begin
            req_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            opnd_q     <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        opnd_q  <= req_data[11*gnt +: 11];
                        id_q    <= gnt;
                        ptr_q   <= ptr_d;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    rsp_data_q <= conv_y;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        cnt_q   <= cnt_q + 16'd1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign conv_x     = opnd_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = id_q;
    assign conv_count = cnt_q;

endmodule

// File: tb/tb_int2float_sched.sv
// Directed bench for int2float_sched: grant order, latency, backpressure,
// pointer skip, mid-operation reset and count wrap.
module tb_int2float_sched;

    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [43:0]     req_data;
    logic [3:0]      req_ready;
    logic [10:0]     conv_x;
    logic [6:0]      conv_y;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [6:0]      rsp_data;
    logic [1:0]      rsp_id;
    logic [15:0]     conv_count;

    int checks   = 0;
    int failures = 0;

    logic [10:0] dat [4];

    int_dummy_t_unused u_none();

    int2float_sched #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .conv_x     (conv_x),
        .conv_y     (conv_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    // Stand-in for the external converter: any fixed function will do.
    function automatic logic [6:0] f(input logic [10:0] x);
        return x[10:4] ^ x[6:0];
    endfunction

    assign conv_y = f(conv_x);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE with req_valid already applied; ends back in IDLE.
    task automatic run_op(input int g);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        #1;
        chk("grant", 32'(req_ready), 32'(oh));
        rsp_ready = 1'b1;
        step();
        chk("conv_ready", 32'(req_ready), 32'h0);
        chk("conv_x", 32'(conv_x), 32'(dat[g]));
        chk("conv_vld", 32'(rsp_valid), 32'h0);
        step();
        chk("rsp_vld", 32'(rsp_valid), 32'h1);
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_data", 32'(rsp_data), 32'(f(dat[g])));
        chk("resp_ready", 32'(req_ready), 32'h0);
        step();
        chk("idle_vld", 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        dat[0] = 11'd5;
        dat[1] = 11'd100;
        dat[2] = 11'd2047;
        dat[3] = 11'd1234;
        for (int i = 0; i < 4; i++) begin
            req_data[11*i +: 11] = dat[i];
        end
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        step();
        step();
        chk("rst_vld", 32'(rsp_valid), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_x", 32'(conv_x), 32'h0);
        chk("rst_data", 32'(rsp_data), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_cnt", 32'(conv_count), 32'h0);

        // Single request from requester 0
        rst       = 1'b0;
        req_valid = 4'b0001;
        run_op(0);
        chk("single_cnt", 32'(conv_count), 32'd1);

        // All contend after a fresh reset
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_op(i % 4);
        end
        chk("contend_cnt", 32'(conv_count), 32'd5);

        // Backpressure on requester 2 (ptr is 1)
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0100);
        step();
        step();
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_vld", 32'(rsp_valid), 32'h1);
            chk("bp_id", 32'(rsp_id), 32'd2);
            chk("bp_data", 32'(rsp_data), 32'(f(dat[2])));
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_cnt", 32'(conv_count), 32'd5);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_done_cnt", 32'(conv_count), 32'd6);
        chk("bp_done_vld", 32'(rsp_valid), 32'h0);

        // Pointer skip: ptr 3 -> grant 1 -> ptr 2
        req_valid = 4'b0010;
        run_op(1);
        req_valid = 4'b0000;
        #1;
        chk("idle_none", 32'(req_ready), 32'h0);
        step();
        step();
        chk("idle_cnt", 32'(conv_count), 32'd7);
        req_valid = 4'b0011;
        run_op(0);
        run_op(1);
        chk("skip_cnt", 32'(conv_count), 32'd9);

        // Reset during CONV
        req_valid = 4'b1000;
        #1;
        chk("mid_grant", 32'(req_ready), 32'b1000);
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mid_vld", 32'(rsp_valid), 32'h0);
        chk("mid_x", 32'(conv_x), 32'h0);
        chk("mid_cnt", 32'(conv_count), 32'h0);
        req_valid = 4'b0001;
        run_op(0);
        chk("mid_after_cnt", 32'(conv_count), 32'd1);

        // Count wrap
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        #1;
        chk("wrap_pre", 32'(conv_count), 32'hFFFF);
        run_op(0);
        chk("wrap_cnt", 32'(conv_count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

module int_dummy_t_unused;
endmodule

// File: doc/int2float_sched.md
INT2FLOAT_SCHED -- requirements
Module: int2float_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one converter (2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port req_valid, input, NREQ bits: per-requester request valid.
REQ-005 The block SHALL have port req_data, input, NREQ*11 bits: per-requester 11-bit integer operand; requester i uses bits [11i+10:11i].
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-requester accept; the handshake completes when valid and ready are both high.
REQ-007 The block SHALL have port conv_x, output, 11 bits: operand driven to the external combinational int2float converter.
REQ-008 The block SHALL have port conv_y, input, 7 bits: converter result.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: response valid.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: consumer accept.
REQ-011 The block SHALL have port rsp_data, output, 7 bits: registered converter result.
REQ-012 The block SHALL have port rsp_id, output, clog2(NREQ) bits: index of the requester that owns rsp_data.
REQ-013 The block SHALL have port conv_count, output, 16 bits: count of completed response handshakes.

Function
REQ-014 The block SHALL implement FSM states IDLE, CONV and RESP.
REQ-015 In IDLE, the block SHALL raise req_ready for exactly one requester, the grant g, and only when at least one req_valid bit is high; all other req_ready bits SHALL be 0.
REQ-016 Grant SHALL be round-robin: search order starts at index ptr and ascends modulo NREQ; g is the first index with req_valid high.
REQ-017 On the IDLE handshake, the block SHALL capture req_data[g] into the operand register, capture g into the id register, set ptr to (g+1) mod NREQ, and go to CONV.
REQ-018 In IDLE with no req_valid bit high, the block SHALL stay in IDLE and leave ptr unchanged.
REQ-019 conv_x SHALL always equal the operand register; the operand register SHALL change only on an IDLE handshake.
REQ-020 In CONV, the block SHALL hold for exactly one cycle, capture conv_y into rsp_data at the end of that cycle, and go to RESP.
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL be stable until the response handshake.
REQ-022 In RESP with rsp_ready high, the block SHALL go to IDLE and increment conv_count; conv_count SHALL wrap from 0xFFFF to 0x0000.
REQ-023 In RESP with rsp_ready low, the block SHALL stay in RESP indefinitely.
REQ-024 req_ready SHALL be 0 in CONV and RESP, so at most one operation is in flight.
REQ-025 Latency SHALL be 2 cycles from the request handshake to rsp_valid; peak throughput SHALL be one operation per 3 cycles.
REQ-026 A requester dropping req_valid before its handshake SHALL lose no state, because grant is re-evaluated every IDLE cycle.
REQ-027 req_ready and rsp_valid SHALL be decoded from registered state only; req_ready may also depend combinationally on req_valid.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL set state=IDLE, ptr=0, operand=0 (so conv_x=0), rsp_data=0, rsp_id=0, rsp_valid=0, req_ready=0 and conv_count=0.
REQ-029 Reset asserted in CONV or RESP SHALL abort the operation with no response issued and no count increment; the aborted requester SHALL re-request.
REQ-030 In the first cycle after reset deassertion, requester 0 SHALL have highest priority.

Verification
REQ-031 Single request: after reset, req_valid=0001, req_data[0]=11'd5, model conv_y=f(5) -> req_ready=0001 in the cycle of request; rsp_valid=1 two cycles later with rsp_id=0, rsp_data=f(5); with rsp_ready=1, conv_count=1.
REQ-032 All contend: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; a new grant every 3 cycles; conv_count=5 after 15 cycles.
REQ-033 Backpressure: rsp_ready=0 for 10 cycles during RESP -> rsp_valid, rsp_data and rsp_id stable; req_ready=0000 throughout; one handshake and +1 count when rsp_ready rises.
REQ-034 Pointer skip: ptr=2 with req_valid=0011 -> grant 0, then ptr=1.
REQ-035 Reset mid-op: rst pulsed during CONV -> next cycle rsp_valid=0, conv_x=0, conv_count unchanged at 0, ptr=0.
REQ-036 Wrap: preload 0xFFFF completed handshakes (or force conv_count=0xFFFF), then one more handshake -> conv_count=0x0000.
